// File: rtl/prim_skid_pkg.sv
// prim_skid_pkg
// Shared definitions for the two-entry skid buffer slice.
//   skid_state_e  : occupancy of the slice (empty, main only, main + skid)
//   SkidStallCntW : width of the optional output-stall counter
// The stall counter is only built when PRIM_SKID_STALL_CNT_EN is defined.
package prim_skid_pkg;

    typedef enum logic [1:0] {
        SkidEmpty = 2'd0,
        SkidOne   = 2'd1,
        SkidTwo   = 2'd2
    } skid_state_e;

    localparam int SkidStallCntW = 16;

endpackage

// File: rtl/prim_skid_sat_cnt.sv
// prim_skid_sat_cnt
// Saturating up-counter: counts clock cycles with inc_i high and sticks at
// all-ones instead of wrapping. It clears only on reset.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset, clears the count
//   inc_i  : increment request for this cycle
//   cnt_o  : current count (registered)
module prim_skid_sat_cnt #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    // Count up on request but hold once every bit is set, so a very long
    // stall reads as "at least this many" rather than wrapping to a small value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prim_skid_buffer.sv
// prim_skid_buffer
// Two-entry valid/ready register slice. Data, valid and ready toward both
// sides come from flops, so no combinational path crosses the slice; one
// transfer per cycle is sustained with one cycle of forward latency.
// The skid register catches the one beat the producer sends in the cycle
// the consumer first stalls, because ready only drops a cycle later.
// Optional feature macro: PRIM_SKID_STALL_CNT_EN (output-stall counter).
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   in_valid_i   : producer has data
//   in_ready_o   : slice can accept (state decode, held low during reset)
//   in_data_i    : producer data
//   out_valid_o  : slice holds data for the consumer
//   out_ready_i  : consumer accepts
//   out_data_o   : head-of-slice data, straight from the main register
//   stall_cnt_o  : saturating count of cycles with out_valid_o && !out_ready_i
//                  (constant zero when the macro is not defined)
module prim_skid_buffer
    import prim_skid_pkg::*;
#(
    parameter int unsigned      Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [Width-1:0]         in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [Width-1:0]         out_data_o,
    output logic [SkidStallCntW-1:0] stall_cnt_o
);

    skid_state_e      state_q, state_d;
    logic [Width-1:0] main_q;
    logic [Width-1:0] skid_q;
    logic             accept;
    logic             consume;

    // Ready and valid are decoded from the state register only. Reset is the
    // one exception: it masks ready so nothing is accepted while it is held.
    assign in_ready_o  = (state_q != SkidTwo) && !rst_i;
    assign out_valid_o = (state_q != SkidEmpty);
    assign out_data_o  = main_q;

    assign accept  = in_valid_i && in_ready_o;
    assign consume = out_valid_o && out_ready_i;

    // Occupancy transitions. In the full state the input side is ignored,
    // since ready is already low there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SkidEmpty: begin
                if (accept) begin
                    state_d = SkidOne;
                end
            end
            SkidOne: begin
                if (accept && !consume) begin
                    state_d = SkidTwo;
                end else if (!accept && consume) begin
                    state_d = SkidEmpty;
                end
            end
            SkidTwo: begin
                if (consume) begin
                    state_d = SkidOne;
                end
            end
            default: state_d = SkidEmpty;
        endcase
    end

    // State and data registers. The data registers only move on a transfer,
    // so out_data_o keeps its old (stale) value while the slice is empty.
    // With one entry held, a simultaneous accept and consume replaces the
    // main entry directly; an accept alone parks the new beat in the skid
    // register behind it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SkidEmpty;
            main_q  <= ResetValue;
            skid_q  <= ResetValue;
        end else begin
            state_q <= state_d;
            case (state_q)
                SkidEmpty: begin
                    if (accept) begin
                        main_q <= in_data_i;
                    end
                end
                SkidOne: begin
                    if (accept && consume) begin
                        main_q <= in_data_i;
                    end else if (accept) begin
                        skid_q <= in_data_i;
                    end
                end
                SkidTwo: begin
                    if (consume) begin
                        main_q <= skid_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PRIM_SKID_STALL_CNT_EN
    // Output-stall monitor: one count per cycle the consumer holds off valid
    // data. The counter's own reset covers the reset-cycle exclusion.
    prim_skid_sat_cnt #(
        .Width (SkidStallCntW)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (out_valid_o && !out_ready_i),
        .cnt_o (stall_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
`endif

endmodule
